compress_dictionary: RTL and testbench

Move-to-front (MTF) dictionary for the Stage1 compressor. It holds `WORDS` 32-bit entries and presents them flat on `dictionary_o`, which drives the byte-level comparator stage. It also accepts one update per handshake from the downstream match-decision logic. Each update reorders or refills the dictionary according to X-Match MTF rules: full hit, partial hit, miss, or skip.

---
 rtl/compress_dictionary.sv | 137 +++++++++++++
 tb/tb_compress_dictionary.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_dictionary.sv
// Move-to-front dictionary for the Stage1 compressor (full/partial/miss/skip).
// Optional hit/miss statistics counters: define COMPRESS_DICT_STATS_EN.
module compress_dictionary #(
  parameter int WIDTH = 32,
  parameter int WORDS = 16,
  parameter int IDXW  = $clog2(WORDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   upd_valid_i,
  output logic                   upd_ready_o,
  input  logic [1:0]             upd_type_i,
  input  logic [IDXW-1:0]        upd_index_i,
  input  logic [WIDTH-1:0]       upd_word_i,
  output logic [WORDS*WIDTH-1:0] dictionary_o,
  output logic [WORDS-1:0]       entry_valid_o,
  output logic [IDXW:0]          fill_count_o,
`ifdef COMPRESS_DICT_STATS_EN
  output logic [15:0]            hit_count_o,
  output logic [15:0]            miss_count_o,
`endif
  output logic                   err_o
);

  typedef enum logic [1:0] {
    UPD_MISS = 2'd0,
    UPD_PART = 2'd1,
    UPD_FULL = 2'd2,
    UPD_SKIP = 2'd3
  } upd_e;

  localparam logic [IDXW:0] FULL_CNT = (IDXW+1)'(WORDS);

  logic [WIDTH-1:0] dict_q [WORDS];
  logic [WIDTH-1:0] dict_d [WORDS];
  logic [WORDS-1:0] valid_q, valid_d;
  logic [IDXW:0]    fill_q, fill_d;
  logic             err_q, err_d;
  logic             accept;
  logic             idx_ok;
  upd_e             upd_type;

  assign upd_ready_o = ~clear_i;
  assign accept      = upd_valid_i & ~clear_i;
  assign idx_ok      = {1'b0, upd_index_i} < fill_q;
  assign upd_type    = upd_e'(upd_type_i);

  // Next-state: flush, or apply one MTF update to the registered contents
  always_comb begin
    dict_d  = dict_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    err_d   = err_q;
    if (clear_i) begin
      for (int i = 0; i < WORDS; i++) dict_d[i] = '0;
      valid_d = '0;
      fill_d  = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      unique case (upd_type)
        UPD_MISS: begin
          for (int i = 1; i < WORDS; i++)
            dict_d[i] = dict_q[i-1];
          dict_d[0] = upd_word_i;
          valid_d   = {valid_q[WORDS-2:0], 1'b1};
          if (fill_q != FULL_CNT)
            fill_d = fill_q + 1'b1;
        end
        UPD_PART, UPD_FULL: begin
          if (!idx_ok) begin
            err_d = 1'b1;
          end else begin
            for (int i = 1; i < WORDS; i++)
              if (i <= int'(upd_index_i))
                dict_d[i] = dict_q[i-1];
            dict_d[0] = (upd_type == UPD_PART) ?
                        upd_word_i : dict_q[upd_index_i];
          end
        end
        UPD_SKIP: ;
      endcase
    end
  end

  // Dictionary state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) dict_q[i] <= '0;
      valid_q <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < WORDS; i++) dict_q[i] <= dict_d[i];
      valid_q <= valid_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_flat
    assign dictionary_o[g*WIDTH +: WIDTH] = dict_q[g];
  end

  assign entry_valid_o = valid_q;
  assign fill_count_o  = fill_q;
  assign err_o         = err_q;

`ifdef COMPRESS_DICT_STATS_EN
  logic [15:0] hit_q, miss_q;
  logic        hit_ev, miss_ev;

  assign hit_ev  = accept & idx_ok &
                   ((upd_type == UPD_PART) | (upd_type == UPD_FULL));
  assign miss_ev = accept & (upd_type == UPD_MISS);

  // Saturating hit/miss statistics, flushed with the dictionary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (clear_i) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_ev && hit_q != 16'hFFFF)
        hit_q <= hit_q + 16'd1;
      if (miss_ev && miss_q != 16'hFFFF)
        miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
`endif

endmodule

// File: tb/tb_compress_dictionary.sv
// Scoreboard bench for compress_dictionary: directed MTF updates,
// queued expectations checked by an independent monitor.
module tb_compress_dictionary;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear_i;
  logic         upd_valid_i;
  logic         upd_ready_o;
  logic [1:0]   upd_type_i;
  logic [3:0]   upd_index_i;
  logic [31:0]  upd_word_i;
  logic [511:0] dictionary_o;
  logic [15:0]  entry_valid_o;
  logic [4:0]   fill_count_o;
  logic         err_o;
`ifdef COMPRESS_DICT_STATS_EN
  logic [15:0]  hit_count_o;
  logic [15:0]  miss_count_o;
`endif

  compress_dictionary dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .upd_valid_i   (upd_valid_i),
    .upd_ready_o   (upd_ready_o),
    .upd_type_i    (upd_type_i),
    .upd_index_i   (upd_index_i),
    .upd_word_i    (upd_word_i),
    .dictionary_o  (dictionary_o),
    .entry_valid_o (entry_valid_o),
    .fill_count_o  (fill_count_o),
`ifdef COMPRESS_DICT_STATS_EN
    .hit_count_o   (hit_count_o),
    .miss_count_o  (miss_count_o),
`endif
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] dict;
    logic [15:0]  vld;
    logic [4:0]   fill;
    logic         err;
    logic [15:0]  hit;
    logic [15:0]  miss;
    string        name;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_d[16];
  int          m_fill;
  logic        m_err;
  int          m_hit;
  int          m_miss;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int i);
    return dictionary_o[i*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_d[i] = '0;
    m_fill = 0;
    m_err  = 1'b0;
    m_hit  = 0;
    m_miss = 0;
  endtask

  task automatic model_apply(input logic v, input logic [1:0] t,
                             input int k, input logic [31:0] w,
                             input logic clr);
    logic [31:0] tmp;
    if (clr) begin
      model_reset();
    end else if (v) begin
      case (t)
        2'd0: begin
          for (int i = 15; i > 0; i--) m_d[i] = m_d[i-1];
          m_d[0] = w;
          if (m_fill < 16) m_fill++;
          m_miss++;
        end
        2'd1, 2'd2: begin
          if (k >= m_fill) begin
            m_err = 1'b1;
          end else begin
            tmp = m_d[k];
            for (int i = k; i > 0; i--) m_d[i] = m_d[i-1];
            m_d[0] = (t == 2'd1) ? w : tmp;
            m_hit++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge state
  task automatic step(input string nm, input logic v,
                      input logic [1:0] t, input int k,
                      input logic [31:0] w, input logic clr);
    exp_t        e;
    logic [16:0] one;
    @(negedge clk);
    upd_valid_i = v;
    upd_type_i  = t;
    upd_index_i = 4'(k);
    upd_word_i  = w;
    clear_i     = clr;
    model_apply(v, t, k, w, clr);
    for (int i = 0; i < 16; i++) e.dict[i*32 +: 32] = m_d[i];
    one    = 17'd1;
    e.vld  = 16'((one << m_fill) - 17'd1);
    e.fill = 5'(m_fill);
    e.err  = m_err;
    e.hit  = 16'(m_hit);
    e.miss = 16'(m_miss);
    e.name = nm;
    sbq.push_back(e);
    #1;
    if (clr) chk({nm, "_ready"}, 512'(upd_ready_o), 512'd0);
    @(posedge clk);
    #2;
    upd_valid_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  // Monitor: compare DUT state against the queued expectation each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.name, "_dict"}, dictionary_o, e.dict);
        chk({e.name, "_vld"}, 512'(entry_valid_o), 512'(e.vld));
        chk({e.name, "_fill"}, 512'(fill_count_o), 512'(e.fill));
        chk({e.name, "_err"}, 512'(err_o), 512'(e.err));
`ifdef COMPRESS_DICT_STATS_EN
        chk({e.name, "_hit"}, 512'(hit_count_o), 512'(e.hit));
        chk({e.name, "_miss"}, 512'(miss_count_o), 512'(e.miss));
`endif
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    clear_i     = 1'b0;
    upd_valid_i = 1'b0;
    upd_type_i  = 2'd0;
    upd_index_i = 4'd0;
    upd_word_i  = 32'd0;
    model_reset();
    #12;
    chk("rst_dict", dictionary_o, 512'd0);
    chk("rst_vld", 512'(entry_valid_o), 512'd0);
    chk("rst_fill", 512'(fill_count_o), 512'd0);
    chk("rst_err", 512'(err_o), 512'd0);
    chk("rst_ready", 512'(upd_ready_o), 512'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill from reset with 0x01..0x10
    for (int i = 1; i <= 16; i++) step("fill", 1, 2'd0, 0, 32'(i), 0);
    chk("fill_e0", 512'(ent(0)), 512'h10);
    chk("fill_e15", 512'(ent(15)), 512'h01);
    chk("fill_cnt", 512'(fill_count_o), 512'd16);
    chk("fill_vld", 512'(entry_valid_o), 512'hFFFF);
    step("miss17", 1, 2'd0, 0, 32'hAA, 0);
    chk("miss17_e0", 512'(ent(0)), 512'hAA);
    chk("miss17_e15", 512'(ent(15)), 512'h02);
    chk("miss17_cnt", 512'(fill_count_o), 512'd16);

    // Full-hit MTF at k=5 on a fresh full dictionary
    step("clr1", 0, 2'd0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) step("refill", 1, 2'd0, 0, 32'(i), 0);
    step("full5", 1, 2'd2, 5, 32'hDEAD, 0);
    chk("full5_e0", 512'(ent(0)), 512'h0B);
    chk("full5_e1", 512'(ent(1)), 512'h10);
    chk("full5_e5", 512'(ent(5)), 512'h0C);
    chk("full5_e6", 512'(ent(6)), 512'h0A);
    chk("full5_e15", 512'(ent(15)), 512'h01);
    chk("full5_cnt", 512'(fill_count_o), 512'd16);
    step("full0", 1, 2'd2, 0, 32'h0, 0);
    chk("full0_e0", 512'(ent(0)), 512'h0B);
    step("full15", 1, 2'd2, 15, 32'h0, 0);
    chk("full15_e0", 512'(ent(0)), 512'h01);

    // Partial-hit replace
    step("clr2", 0, 2'd0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("fill4", 1, 2'd0, 0, 32'h21 + i, 0);
    step("part3", 1, 2'd1, 3, 32'h12345678, 0);
    chk("part3_e0", 512'(ent(0)), 512'h12345678);
    chk("part3_e1", 512'(ent(1)), 512'h24);
    chk("part3_e3", 512'(ent(3)), 512'h22);
    chk("part3_e4", 512'(ent(4)), 512'h0);
    chk("part3_cnt", 512'(fill_count_o), 512'd4);

    // Skip and invalid index
    step("clr3", 0, 2'd0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("fill3", 1, 2'd0, 0, 32'h31 + i, 0);
    step("skip", 1, 2'd3, 1, 32'h99, 0);
    step("bad7", 1, 2'd2, 7, 32'h0, 0);
    chk("bad7_err", 512'(err_o), 512'd1);
    step("bad3", 1, 2'd1, 3, 32'h77, 0);
    step("idle", 0, 2'd0, 0, 0, 0);
    step("okfull2", 1, 2'd2, 2, 32'h0, 0);
    chk("sticky_err", 512'(err_o), 512'd1);
    chk("ok2_e0", 512'(ent(0)), 512'h31);

    // Clear versus update collision
    step("collide", 1, 2'd0, 0, 32'h55, 1);
    chk("collide_cnt", 512'(fill_count_o), 512'd0);
    chk("collide_err", 512'(err_o), 512'd0);
    step("empty_part", 1, 2'd1, 0, 32'h66, 0);
    chk("empty_err", 512'(err_o), 512'd1);
    step("clr4", 0, 2'd0, 0, 0, 1);

    // Async reset during back-to-back updates
    for (int i = 0; i < 3; i++) step("b2b", 1, 2'd0, 0, 32'h41 + i, 0);
    step("b2b_hit", 1, 2'd2, 2, 32'h0, 0);
    repeat (2) @(posedge clk);
    if (sbq.size() != 0) chk("sb_drain", 512'(sbq.size()), 512'd0);
    @(negedge clk);
    upd_valid_i = 1'b1;
    upd_type_i  = 2'd0;
    upd_word_i  = 32'hBEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dict", dictionary_o, 512'd0);
    chk("arst_vld", 512'(entry_valid_o), 512'd0);
    chk("arst_fill", 512'(fill_count_o), 512'd0);
`ifdef COMPRESS_DICT_STATS_EN
    chk("arst_hit", 512'(hit_count_o), 512'd0);
    chk("arst_miss", 512'(miss_count_o), 512'd0);
`endif
    @(posedge clk);
    #2;
    chk("arst_hold", 512'(fill_count_o), 512'd0);
    upd_valid_i = 1'b0;
    rst_n       = 1'b1;
    model_reset();
    step("post_rst", 1, 2'd0, 0, 32'hC0DE, 0);
    chk("post_rst_e0", 512'(ent(0)), 512'hC0DE);

    repeat (3) @(posedge clk);
    #3;
    if (sbq.size() != 0) chk("sb_final", 512'(sbq.size()), 512'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
